prbs31_seq_ctrl: RTL
====================

PRBS31_SEQ_CTRL -- requirements
Module: prbs31_seq_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  clock, all state on rising edge.
REQ-002 SHALL have ports: rst_n  in  1  reset, asynchronous, active-high.
REQ-003 SHALL have ports: cfg_valid  in  1 / cfg_ready  out  1  configuration handshake.
REQ-004 SHALL have ports: cfg_mode  in  1  0=generate, 1=check; cfg_len  in  16  byte count, 0=continuous; cfg_seed  in  31  LFSR seed.
REQ-005 SHALL have ports: abort  in  1  stop current run.
REQ-006 SHALL have ports: out_valid  out  1 / out_ready  in  1 / out_data  out  8  generated byte stream.
REQ-007 SHALL have ports: rx_valid  in  1 / rx_data  in  8  received bytes for check mode.
REQ-008 SHALL have ports: busy  out  1, done  out  1 (pulse), err_cnt  out  16  bit-error count.

Function
REQ-009 SHALL implement PRBS31 (x^31+x^28+1): new bit = s[30]^s[27], s <= {s[29:0], new}, 8 steps per byte advance.
REQ-010 SHALL present the first generated bit of a byte on data bit 7, the eighth on bit 0.
REQ-011 SHALL have FSM states IDLE, LOAD, RUN, DONE.
REQ-012 SHALL assert cfg_ready only in IDLE; cfg_valid&&cfg_ready SHALL latch mode/len/seed and go to LOAD.
REQ-013 SHALL, in LOAD (exactly one cycle), load the seed into the LFSR; a zero seed SHALL be replaced by 31'h7FFFFFFF; err_cnt SHALL clear; next state RUN.
REQ-014 Generate mode: in RUN out_valid=1; out_data = byte from current state; the LFSR SHALL advance one byte and the remaining count SHALL decrement only on out_valid&&out_ready.
REQ-015 Check mode: out_valid=0; on rx_valid the LFSR SHALL advance one byte, err_cnt SHALL add popcount(rx_data ^ expected byte), and the count SHALL decrement.
REQ-016 err_cnt SHALL saturate at 16'hFFFF and hold its value until the next LOAD.
REQ-017 When the byte completing a cfg_len>0 run is accepted, the FSM SHALL enter DONE; cfg_len=0 SHALL never terminate except via abort.
REQ-018 DONE SHALL last one cycle with done=1, then IDLE; out_valid SHALL be 0 in DONE.
REQ-019 abort in LOAD or RUN SHALL go to IDLE next cycle without a done pulse; a byte handshaked in the same cycle SHALL still count; abort in IDLE/DONE SHALL be ignored.
REQ-020 busy SHALL be 1 in LOAD, RUN and DONE, 0 in IDLE.
REQ-021 out_data SHALL remain stable while out_valid=1 and out_ready=0.

Reset
REQ-022 rst_n=1 SHALL asynchronously force IDLE, LFSR=31'h7FFFFFFF, count=0, err_cnt=0, out_valid=0, done=0, busy=0; cfg_ready=1 after release.
REQ-023 Reset mid-run SHALL discard the run with no done pulse.

Structure
REQ-024 A shared package SHALL hold the FSM state enum, the mode encoding, PRBS31 tap constants (30, 27) and the zero-seed substitute 31'h7FFFFFFF.
REQ-025 One sub-module prbs31_core SHALL hold the 31-bit LFSR with load/advance inputs and a combinational 8-bit output; the controller holds the FSM, count and error logic.

Verification
REQ-026 Gen, seed 31'h40000000, len 1, out_ready=1 -> one byte 0x80, done pulse the cycle after, then cfg_ready=1.
REQ-027 Gen, seed 0, len 3 -> seed treated as 31'h7FFFFFFF, bytes 0x00,0x00,0x00, done=1 once.
REQ-028 Gen len 4, out_ready held 0 for 5 cycles mid-run -> out_data stable, exactly 4 bytes total, no skips.
REQ-029 Check, seed 31'h40000000, len 2, rx 0x81 then the correct second byte -> err_cnt=1 at done.
REQ-030 Gen len 0 for 100 bytes, then abort -> IDLE next cycle, no done, busy=0.
REQ-031 Assert rst_n mid-RUN -> all outputs at reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/prbs31_seq_ctrl_pkg.sv
// Shared types and constants for the PRBS31 sequence generator/checker.
// Holds the controller state encoding, run modes, LFSR taps and seed values.
package prbs31_seq_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    typedef enum logic {
        MODE_GEN   = 1'b0,
        MODE_CHECK = 1'b1
    } mode_e;

    localparam int TAP_HI = 30;
    localparam int TAP_LO = 27;

    // An all-zero LFSR would lock up, so a zero seed is swapped for all-ones.
    localparam logic [30:0] ZERO_SEED_SUB = 31'h7FFF_FFFF;
    localparam logic [30:0] LFSR_RESET    = 31'h7FFF_FFFF;

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] c;
        c = '0;
        for (int i = 0; i < 8; i++) begin
            c = c + {3'd0, v[i]};
        end
        return c;
    endfunction

endpackage

// File: rtl/prbs31_seq_ctrl_core.sv
// 31-bit PRBS31 LFSR; byte_o is the next eight generated bits, first bit on bit 7.
// advance_i steps the register by a whole byte, load_i replaces it with the seed.
module prbs31_core
    import prbs31_seq_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_i,
    input  logic [30:0] seed_i,
    input  logic        advance_i,
    output logic [7:0]  byte_o
);

    logic [30:0] lfsr_q, lfsr_d;
    logic [30:0] walk;
    logic [7:0]  byteBits;

    // Unroll eight shifts so the byte and the post-byte state come out together.
    always_comb begin
        walk     = lfsr_q;
        byteBits = '0;
        for (int i = 0; i < 8; i++) begin
            byteBits[7-i] = walk[TAP_HI] ^ walk[TAP_LO];
            walk          = {walk[29:0], byteBits[7-i]};
        end
    end

    always_comb begin
        lfsr_d = lfsr_q;
        if (load_i) begin
            lfsr_d = (seed_i == '0) ? ZERO_SEED_SUB : seed_i;
        end else if (advance_i) begin
            lfsr_d = walk;
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            lfsr_q <= LFSR_RESET;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign byte_o = byteBits;

endmodule

// File: rtl/prbs31_seq_ctrl.sv
// PRBS31 run controller: accepts a configuration, then either streams generated
// bytes or compares received bytes against the sequence and counts bit errors.
module prbs31_seq_ctrl
    import prbs31_seq_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cfg_valid,
    output logic        cfg_ready,
    input  logic        cfg_mode,
    input  logic [15:0] cfg_len,
    input  logic [30:0] cfg_seed,
    input  logic        abort,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_data,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        busy,
    output logic        done,
    output logic [15:0] err_cnt
);

    state_e      state_q, state_d;
    mode_e       mode_q, mode_d;
    logic [15:0] count_q, count_d;
    logic        contRun_q, contRun_d;
    logic [30:0] seed_q, seed_d;
    logic [15:0] err_q, err_d;

    logic        lfsrLoad;
    logic        lfsrAdvance;
    logic        byteFire;
    logic [7:0]  expByte;
    logic [16:0] errSum;

    prbs31_core u_core (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_i    (lfsrLoad),
        .seed_i    (seed_q),
        .advance_i (lfsrAdvance),
        .byte_o    (expByte)
    );

    assign errSum = {1'b0, err_q} + {13'd0, popcount8(rx_data ^ expByte)};

    // Abort outranks run completion so an aborted last byte never pulses done.
    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        count_d     = count_q;
        contRun_d   = contRun_q;
        seed_d      = seed_q;
        err_d       = err_q;
        lfsrLoad    = 1'b0;
        lfsrAdvance = 1'b0;
        byteFire    = 1'b0;
        cfg_ready   = 1'b0;
        out_valid   = 1'b0;
        busy        = 1'b1;
        done        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cfg_ready = 1'b1;
                busy      = 1'b0;
                if (cfg_valid) begin
                    mode_d    = mode_e'(cfg_mode);
                    count_d   = cfg_len;
                    contRun_d = (cfg_len == 16'd0);
                    seed_d    = cfg_seed;
                    state_d   = ST_LOAD;
                end
            end
            ST_LOAD: begin
                lfsrLoad = 1'b1;
                err_d    = '0;
                state_d  = abort ? ST_IDLE : ST_RUN;
            end
            ST_RUN: begin
                if (mode_q == MODE_GEN) begin
                    out_valid = 1'b1;
                    byteFire  = out_ready;
                end else begin
                    byteFire = rx_valid;
                    if (rx_valid) begin
                        err_d = errSum[16] ? 16'hFFFF : errSum[15:0];
                    end
                end
                if (byteFire) begin
                    lfsrAdvance = 1'b1;
                    count_d     = count_q - 16'd1;
                end
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (byteFire && !contRun_q && (count_q == 16'd1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q   <= ST_IDLE;
            mode_q    <= MODE_GEN;
            count_q   <= '0;
            contRun_q <= 1'b0;
            seed_q    <= '0;
            err_q     <= '0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            count_q   <= count_d;
            contRun_q <= contRun_d;
            seed_q    <= seed_d;
            err_q     <= err_d;
        end
    end

    assign out_data = expByte;
    assign err_cnt  = err_q;

endmodule
